// File: rtl/serial_frame_rx_ctrl.sv
// serial_frame_rx_ctrl: idle-high serial receiver with mid-bit sampling, MSB-first shift and a
// valid/ready output that reports overrun and framing errors.
module serial_frame_rx_ctrl #(
  parameter int DATA_W = 8,
  parameter int DIV    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              serial_in,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);
  localparam int TW = $clog2(DIV);
  localparam int BW = $clog2(DATA_W + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t            state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d, out_data_q, out_data_d;
  logic              in_d_q, out_valid_q, out_valid_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic              load;
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q + TW'(1);
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    load        = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        tick_d = '0;
        if (in_d_q && !serial_in) state_d = START;
      end
      START: if (tick_q == TW'(DIV / 2 - 1)) begin
        tick_d  = '0;
        bit_d   = '0;
        state_d = serial_in ? IDLE : DATA;
      end
      DATA: if (tick_q == TW'(DIV - 1)) begin
        tick_d  = '0;
        shreg_d = (shreg_q << 1) | DATA_W'(serial_in);
        bit_d   = bit_q + BW'(1);
        if (bit_q == BW'(DATA_W - 1)) state_d = STOP;
      end
      default: if (tick_q == TW'(DIV - 1)) begin
        tick_d      = '0;
        state_d     = IDLE;
        load        = serial_in;
        frame_err_d = !serial_in;
      end
    endcase
    // a transfer in the load cycle consumes the old word, so only an unaccepted word counts as overrun
    out_data_d  = load ? shreg_q : out_data_q;
    out_valid_d = load || (out_valid_q && !out_ready);
    overrun_d   = load && out_valid_q && !out_ready;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      in_d_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      in_d_q      <= serial_in;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end
  assign busy      = state_q != IDLE;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_serial_frame_rx_ctrl.sv
// tb_serial_frame_rx_ctrl: directed and randomized line waveforms checked cycle by cycle against
// a frame-level decoder of the line plus the output handshake rules.
module tb_serial_frame_rx_ctrl;
  localparam int DATA_W = 8;
  localparam int DIV    = 4;
  localparam int MAXN   = 1024;
  logic clk, reset, serial_in, out_ready;
  logic [DATA_W-1:0] out_data;
  logic out_valid, busy, frame_err, overrun;
  int checks = 0;
  int errors = 0;
  logic wave [0:MAXN-1];
  logic rdy [0:MAXN-1];
  int wn;
  logic rdy_def;
  logic [DATA_W+3:0] obs [0:MAXN];
  logic [DATA_W+3:0] expv [0:MAXN];
  logic bz [0:MAXN];
  logic ld [0:MAXN];
  logic fe [0:MAXN];
  logic [DATA_W-1:0] lw [0:MAXN];
  logic m_prev, m_valid;
  logic [DATA_W-1:0] m_data;

  serial_frame_rx_ctrl #(.DATA_W(DATA_W), .DIV(DIV)) dut (
    .clk(clk), .reset(reset), .serial_in(serial_in), .out_ready(out_ready),
    .out_data(out_data), .out_valid(out_valid), .busy(busy),
    .frame_err(frame_err), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic put(input logic b, input int cyc);
    for (int i = 0; i < cyc; i++) begin
      wave[wn] = b;
      rdy[wn]  = rdy_def;
      wn++;
    end
  endtask

  task automatic put_frame(input logic [DATA_W-1:0] d, input logic stop);
    put(1'b0, DIV);
    for (int i = DATA_W - 1; i >= 0; i--) put(d[i], DIV);
    put(stop, DIV);
  endtask

  // Decode the line as frames (start edge, mid-bit samples) then apply the handshake rules.
  task automatic build_model();
    int s, last, idle_from;
    logic p, v, ov;
    logic [DATA_W-1:0] w, d;
    for (int k = 0; k <= wn; k++) begin
      bz[k] = 1'b0; ld[k] = 1'b0; fe[k] = 1'b0; lw[k] = '0;
    end
    idle_from = 0;
    for (int c = 0; c < wn; c++) begin
      p = (c == 0) ? m_prev : wave[c-1];
      if (c >= idle_from && p && !wave[c]) begin
        s = c + DIV / 2;
        if (wave[s]) last = s;
        else begin
          w = '0;
          for (int i = 1; i <= DATA_W; i++) w = (w << 1) | DATA_W'(wave[s + DIV * i]);
          last = s + DIV * (DATA_W + 1);
          if (wave[last]) begin
            ld[last+1] = 1'b1;
            lw[last+1] = w;
          end else fe[last+1] = 1'b1;
        end
        for (int j = c + 1; j <= last; j++) bz[j] = 1'b1;
        idle_from = last + 1;
      end
    end
    v = m_valid;
    d = m_data;
    expv[0] = {bz[0], v, 2'b00, d};
    for (int k = 1; k <= wn; k++) begin
      ov = ld[k] && v && !rdy[k-1];
      v  = ld[k] || (v && !rdy[k-1]);
      d  = ld[k] ? lw[k] : d;
      expv[k] = {bz[k], v, fe[k], ov, d};
    end
    m_prev  = wave[wn-1];
    m_valid = v;
    m_data  = d;
  endtask

  task automatic play(input int n);
    obs[0] = {busy, out_valid, frame_err, overrun, out_data};
    for (int k = 0; k < n; k++) begin
      serial_in = wave[k];
      out_ready = rdy[k];
      @(posedge clk);
      #1;
      obs[k+1] = {busy, out_valid, frame_err, overrun, out_data};
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; serial_in = 1'b1; out_ready = 1'b0;
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({busy, out_valid, frame_err, overrun, out_data} !== '0) begin
      errors++;
      $display("FAIL reset_async got %h expected 0", {busy, out_valid, frame_err, overrun, out_data});
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, out_valid, frame_err, overrun, out_data} !== '0) begin
      errors++;
      $display("FAIL reset_hold got %h expected 0", {busy, out_valid, frame_err, overrun, out_data});
    end
    reset = 1'b0;
    m_prev = 1'b0; m_valid = 1'b0; m_data = '0;
  endtask

  task automatic test_basic();
    wn = 0; rdy_def = 1'b1;
    put(1'b1, 4); put_frame(8'hA5, 1'b1); put(1'b1, 8);
    build_model(); play(wn);
    for (int k = 0; k <= wn; k++) begin
      checks++;
      if (obs[k] !== expv[k]) begin errors++; $display("FAIL basic cycle %0d got %h expected %h", k, obs[k], expv[k]); end
    end
    checks++;
    if (obs[42] !== {4'b1000, 8'h00}) begin errors++; $display("FAIL basic_stop_busy got %h expected %h", obs[42], {4'b1000, 8'h00}); end
    checks++;
    if (obs[43] !== {4'b0100, 8'hA5}) begin errors++; $display("FAIL basic_latency got %h expected %h", obs[43], {4'b0100, 8'hA5}); end
    checks++;
    if (obs[44] !== {4'b0000, 8'hA5}) begin errors++; $display("FAIL basic_consumed got %h expected %h", obs[44], {4'b0000, 8'hA5}); end
  endtask

  task automatic test_glitch();
    wn = 0; rdy_def = 1'b1;
    put(1'b1, 4); put(1'b0, 1); put(1'b1, 12);
    build_model(); play(wn);
    for (int k = 0; k <= wn; k++) begin
      checks++;
      if (obs[k] !== expv[k]) begin errors++; $display("FAIL glitch cycle %0d got %h expected %h", k, obs[k], expv[k]); end
    end
    checks++;
    if (obs[7] !== {4'b0000, 8'hA5}) begin errors++; $display("FAIL glitch_idle got %h expected %h", obs[7], {4'b0000, 8'hA5}); end
  endtask

  task automatic test_frame_err();
    wn = 0; rdy_def = 1'b1;
    put(1'b1, 4); put_frame(8'h3C, 1'b0); put(1'b1, 8);
    build_model(); play(wn);
    for (int k = 0; k <= wn; k++) begin
      checks++;
      if (obs[k] !== expv[k]) begin errors++; $display("FAIL frame_err cycle %0d got %h expected %h", k, obs[k], expv[k]); end
    end
    checks++;
    if (obs[43] !== {4'b0010, 8'hA5}) begin errors++; $display("FAIL frame_err_pulse got %h expected %h", obs[43], {4'b0010, 8'hA5}); end
    checks++;
    if (obs[44] !== {4'b0000, 8'hA5}) begin errors++; $display("FAIL frame_err_single got %h expected %h", obs[44], {4'b0000, 8'hA5}); end
  endtask

  task automatic test_overrun();
    wn = 0; rdy_def = 1'b0;
    put(1'b1, 4); put_frame(8'h11, 1'b1); put_frame(8'h22, 1'b1); put(1'b1, 6);
    rdy_def = 1'b1; put(1'b1, 1);
    rdy_def = 1'b0; put(1'b1, 6);
    build_model(); play(wn);
    for (int k = 0; k <= wn; k++) begin
      checks++;
      if (obs[k] !== expv[k]) begin errors++; $display("FAIL overrun cycle %0d got %h expected %h", k, obs[k], expv[k]); end
    end
    checks++;
    if (obs[43] !== {4'b0100, 8'h11}) begin errors++; $display("FAIL overrun_first got %h expected %h", obs[43], {4'b0100, 8'h11}); end
    checks++;
    if (obs[83] !== {4'b0101, 8'h22}) begin errors++; $display("FAIL overrun_pulse got %h expected %h", obs[83], {4'b0101, 8'h22}); end
    checks++;
    if (obs[91] !== {4'b0000, 8'h22}) begin errors++; $display("FAIL overrun_drain got %h expected %h", obs[91], {4'b0000, 8'h22}); end
  endtask

  task automatic test_load_transfer();
    wn = 0; rdy_def = 1'b0;
    put(1'b1, 4); put_frame(8'h11, 1'b1); put_frame(8'h22, 1'b1); put(1'b1, 8);
    rdy[82] = 1'b1;
    build_model(); play(wn);
    for (int k = 0; k <= wn; k++) begin
      checks++;
      if (obs[k] !== expv[k]) begin errors++; $display("FAIL load_transfer cycle %0d got %h expected %h", k, obs[k], expv[k]); end
    end
    checks++;
    if (obs[83] !== {4'b0100, 8'h22}) begin errors++; $display("FAIL load_transfer_word got %h expected %h", obs[83], {4'b0100, 8'h22}); end
  endtask

  task automatic test_reset_mid();
    wn = 0; rdy_def = 1'b1;
    put(1'b1, 4); put_frame(8'h5A, 1'b1); put(1'b1, 4);
    play(25);
    checks++;
    if (obs[25][DATA_W+3] !== 1'b1) begin errors++; $display("FAIL reset_mid_busy got %b expected 1", obs[25][DATA_W+3]); end
    serial_in = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, out_valid, frame_err, overrun, out_data} !== '0) begin
      errors++;
      $display("FAIL reset_mid_clear got %h expected 0", {busy, out_valid, frame_err, overrun, out_data});
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_prev = 1'b0; m_valid = 1'b0; m_data = '0;
    wn = 0;
    put(1'b0, 6); put(1'b1, 3); put_frame(8'hF0, 1'b1); put(1'b1, 8);
    build_model(); play(wn);
    for (int k = 0; k <= wn; k++) begin
      checks++;
      if (obs[k] !== expv[k]) begin errors++; $display("FAIL reset_mid cycle %0d got %h expected %h", k, obs[k], expv[k]); end
    end
    checks++;
    if (obs[5] !== '0) begin errors++; $display("FAIL reset_mid_low_line got %h expected 0", obs[5]); end
    checks++;
    if (obs[48] !== {4'b0100, 8'hF0}) begin errors++; $display("FAIL reset_mid_frame got %h expected %h", obs[48], {4'b0100, 8'hF0}); end
  endtask

  task automatic test_random();
    wn = 0; rdy_def = 1'b1;
    put(1'b1, 3);
    for (int f = 0; f < 8; f++) begin
      if ($urandom_range(0, 4) == 0) begin put(1'b0, 1); put(1'b1, DIV); end
      put_frame(DATA_W'($urandom), $urandom_range(0, 3) != 0);
      put(1'b1, $urandom_range(0, 2 * DIV));
    end
    put(1'b1, (DATA_W + 3) * DIV);
    for (int k = 0; k < wn; k++) rdy[k] = 1'($urandom_range(0, 1));
    build_model(); play(wn);
    for (int k = 0; k <= wn; k++) begin
      checks++;
      if (obs[k] !== expv[k]) begin errors++; $display("FAIL random cycle %0d got %h expected %h", k, obs[k], expv[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_load_transfer();
    test_reset_mid();
    for (int r = 0; r < 4; r++) test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
